// File: rtl/semaforo_cruzamento_if.sv
// semaforo_cruzamento_if
// Signal bundle between the operator/sensor side and the intersection
// controller.
//   master : drives pulso, modo_manual (and pisca); observes lamps, fase, pulso_edge
//   slave  : the controller itself
// Optional macro SEMAFORO_PISCA_EN adds the pisca (flashing-yellow) request.
interface semaforo_cruzamento_if;
  logic       pulso;
  logic       modo_manual;
`ifdef SEMAFORO_PISCA_EN
  logic       pisca;
`endif
  logic       vermelho_a;
  logic       amarelo_a;
  logic       verde_a;
  logic       vermelho_b;
  logic       amarelo_b;
  logic       verde_b;
  logic [2:0] fase;
  logic       pulso_edge;

  modport master (
`ifdef SEMAFORO_PISCA_EN
    output pisca,
`endif
    output pulso,
    output modo_manual,
    input  vermelho_a,
    input  amarelo_a,
    input  verde_a,
    input  vermelho_b,
    input  amarelo_b,
    input  verde_b,
    input  fase,
    input  pulso_edge
  );

  modport slave (
`ifdef SEMAFORO_PISCA_EN
    input  pisca,
`endif
    input  pulso,
    input  modo_manual,
    output vermelho_a,
    output amarelo_a,
    output verde_a,
    output vermelho_b,
    output amarelo_b,
    output verde_b,
    output fase,
    output pulso_edge
  );
endinterface

// File: rtl/semaforo_cruzamento.sv
// semaforo_cruzamento
// Two-approach intersection controller. Approaches A and B alternate
// green / yellow / all-red phases with parameterised durations. A rising
// edge on pulso cuts the current green short (timed mode) or steps one
// phase (manual mode).
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; returns to INICIO with both reds on
//   bus    : semaforo_cruzamento_if.slave
//            in : pulso, modo_manual (pisca with SEMAFORO_PISCA_EN)
//            out: six lamps, fase (state code), pulso_edge (1-cycle strobe)
// Optional macro SEMAFORO_PISCA_EN adds the PISCA state (fase 7), the pisca
// input and parameter T_PISCA: both yellows flash while pisca is high.
module semaforo_cruzamento #(
  parameter int T_VERDE    = 8,
  parameter int T_AMARELO  = 3,
  parameter int T_VERMELHO = 2,
`ifdef SEMAFORO_PISCA_EN
  parameter int T_PISCA    = 4,
`endif
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  semaforo_cruzamento_if.slave bus
);

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    VERDE_A    = 3'd1,
    AMARELO_A  = 3'd2,
    VERMELHO_1 = 3'd3,
    VERDE_B    = 3'd4,
    AMARELO_B  = 3'd5,
    VERMELHO_2 = 3'd6
`ifdef SEMAFORO_PISCA_EN
    , PISCA    = 3'd7
`endif
  } estado_t;

  localparam logic [CNT_W-1:0] FIM_VERDE    = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] FIM_AMARELO  = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0] FIM_VERMELHO = CNT_W'(T_VERMELHO - 1);
`ifdef SEMAFORO_PISCA_EN
  localparam logic [CNT_W-1:0] FIM_PISCA    = CNT_W'(T_PISCA - 1);
`endif

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulso_q;
  logic             pulso_edge;
  logic             em_verde;
  logic             expirou;
`ifdef SEMAFORO_PISCA_EN
  logic             blink_q, blink_d;
`endif

  // Fixed phase order; anything outside the ring restarts from INICIO.
  function automatic estado_t proxima(input estado_t s);
    case (s)
      VERDE_A:    proxima = AMARELO_A;
      AMARELO_A:  proxima = VERMELHO_1;
      VERMELHO_1: proxima = VERDE_B;
      VERDE_B:    proxima = AMARELO_B;
      AMARELO_B:  proxima = VERMELHO_2;
      VERMELHO_2: proxima = VERDE_A;
      default:    proxima = INICIO;
    endcase
  endfunction

  // Last counter value of a phase (duration - 1).
  function automatic logic [CNT_W-1:0] fim_de(input estado_t s);
    case (s)
      VERDE_A, VERDE_B:       fim_de = FIM_VERDE;
      AMARELO_A, AMARELO_B:   fim_de = FIM_AMARELO;
      VERMELHO_1, VERMELHO_2: fim_de = FIM_VERMELHO;
      default:                fim_de = '0;
    endcase
  endfunction

  assign pulso_edge     = bus.pulso & ~pulso_q;
  assign bus.pulso_edge = pulso_edge;
  assign bus.fase       = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INICIO;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
`ifdef SEMAFORO_PISCA_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulso_q <= bus.pulso;
`ifdef SEMAFORO_PISCA_EN
      blink_q <= blink_d;
`endif
    end
  end

  // cnt_d defaults to 0 so every state change, manual mode and INICIO all
  // leave the counter cleared; only a timed stay increments it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    em_verde = (state_q == VERDE_A) || (state_q == VERDE_B);
    expirou  = (cnt_q == fim_de(state_q));
`ifdef SEMAFORO_PISCA_EN
    blink_d  = blink_q;
    if (bus.pisca) begin
      if (state_q != PISCA) begin
        state_d = PISCA;
        blink_d = 1'b1;
      end else if (cnt_q == FIM_PISCA) begin
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == PISCA) begin
      state_d = INICIO;
    end else
`endif
    if (state_q == INICIO) begin
      state_d = VERDE_A;
    end else if (bus.modo_manual) begin
      if (pulso_edge) state_d = proxima(state_q);
    end else begin
      // Early cut applies to greens only; a strobe coinciding with the
      // timeout still yields a single advance.
      if (expirou || (pulso_edge && em_verde)) state_d = proxima(state_q);
      else                                      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Moore lamp decode, exactly one lamp per approach outside PISCA.
  always_comb begin
    bus.vermelho_a = 1'b0;
    bus.amarelo_a  = 1'b0;
    bus.verde_a    = 1'b0;
    bus.vermelho_b = 1'b0;
    bus.amarelo_b  = 1'b0;
    bus.verde_b    = 1'b0;
    case (state_q)
      VERDE_A: begin
        bus.verde_a    = 1'b1;
        bus.vermelho_b = 1'b1;
      end
      AMARELO_A: begin
        bus.amarelo_a  = 1'b1;
        bus.vermelho_b = 1'b1;
      end
      VERDE_B: begin
        bus.vermelho_a = 1'b1;
        bus.verde_b    = 1'b1;
      end
      AMARELO_B: begin
        bus.vermelho_a = 1'b1;
        bus.amarelo_b  = 1'b1;
      end
`ifdef SEMAFORO_PISCA_EN
      PISCA: begin
        bus.amarelo_a  = blink_q;
        bus.amarelo_b  = blink_q;
      end
`endif
      default: begin
        bus.vermelho_a = 1'b1;
        bus.vermelho_b = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_semaforo_cruzamento.sv
// tb_semaforo_cruzamento
// Self-checking bench for semaforo_cruzamento. Expected fase/lamp values are
// pushed to a scoreboard when stimulus is applied and popped after each edge.
// Build with +define+SEMAFORO_PISCA_EN to also exercise the PISCA state.
module tb_semaforo_cruzamento;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;

  semaforo_cruzamento_if bus ();

  semaforo_cruzamento dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sb_q[$];
  int lamp_q[$];

  logic [5:0] lamps;
  assign lamps = {bus.vermelho_a, bus.amarelo_a, bus.verde_a,
                  bus.vermelho_b, bus.amarelo_b, bus.verde_b};

  // Lamp pattern {vm_a, am_a, vd_a, vm_b, am_b, vd_b} for each fase code.
  function automatic logic [5:0] lamps_of(input int f);
    case (f)
      1:       lamps_of = 6'b001_100;
      2:       lamps_of = 6'b010_100;
      4:       lamps_of = 6'b100_001;
      5:       lamps_of = 6'b100_010;
      default: lamps_of = 6'b100_100;
    endcase
  endfunction

  function automatic int seguinte(input int f);
    seguinte = (f == 6) ? 1 : f + 1;
  endfunction

  task automatic push_exp(input int f);
    sb_q.push_back(f);
    lamp_q.push_back(int'(lamps_of(f)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fase(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.fase == 3'(target)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // One lamp per approach on every cycle (PISCA excluded).
  always @(negedge clk) begin
    if (chk_en && bus.fase !== 3'd7) begin
      n_checks++;
      if ($countones(lamps[5:3]) != 1 || $countones(lamps[2:0]) != 1)
        $display("FAIL one_lamp t=%0t lamps=%b required one-hot per approach", $time, lamps);
      else
        n_pass++;
    end
  end

  task automatic test_reset;
    int ef;
    reset = 1'b1;
    bus.pulso = 1'b0;
    bus.modo_manual = 1'b0;
`ifdef SEMAFORO_PISCA_EN
    bus.pisca = 1'b0;
`endif
    tick();
    tick();
    chk_en = 1'b1;
    push_exp(0);
    ef = sb_q.pop_front();
    n_checks++;
    if (bus.fase !== 3'(ef)) $display("FAIL reset_fase got=%0d exp=%0d", bus.fase, ef);
    else n_pass++;
    n_checks++;
    if (lamps !== 6'(lamp_q.pop_front())) $display("FAIL reset_lamps got=%b exp=100100", lamps);
    else n_pass++;
    n_checks++;
    if (bus.pulso_edge !== 1'b0) $display("FAIL reset_edge got=%b exp=0", bus.pulso_edge);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.fase !== 3'd0) $display("FAIL release_fase got=%0d exp=0", bus.fase);
    else n_pass++;
  endtask

  task automatic test_timed_sequence;
    int dur[6] = '{8, 3, 2, 8, 3, 2};
    int ef, el;
    for (int s = 1; s <= 6; s++)
      for (int k = 0; k < dur[s-1]; k++) push_exp(s);
    push_exp(1);
    while (sb_q.size() > 0) begin
      tick();
      ef = sb_q.pop_front();
      el = lamp_q.pop_front();
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL timed_fase t=%0t got=%0d exp=%0d", $time, bus.fase, ef);
      else n_pass++;
      n_checks++;
      if (lamps !== 6'(el)) $display("FAIL timed_lamps t=%0t got=%b exp=%b", $time, lamps, 6'(el));
      else n_pass++;
    end
  endtask

  // Starts in VERDE_A with cnt 0.
  task automatic test_pulso_green;
    int exp_tab[19] = '{2,2,3,3,4,4,4,4,4,4,4,4,5,5,5,6,6,1,1};
    int ef;
    push_exp(1);
    tick();
    ef = sb_q.pop_front();
    void'(lamp_q.pop_front());
    n_checks++;
    if (bus.fase !== 3'(ef)) $display("FAIL green_pre got=%0d exp=%0d", bus.fase, ef);
    else n_pass++;
    bus.pulso = 1'b1;
    #1;
    n_checks++;
    if (bus.pulso_edge !== 1'b1) $display("FAIL edge_strobe got=%b exp=1", bus.pulso_edge);
    else n_pass++;
    push_exp(2);
    tick();
    ef = sb_q.pop_front();
    void'(lamp_q.pop_front());
    n_checks++;
    if (bus.fase !== 3'(ef)) $display("FAIL green_cut got=%0d exp=%0d", bus.fase, ef);
    else n_pass++;
    for (int i = 0; i < 19; i++) begin
      push_exp(exp_tab[i]);
      n_checks++;
      if (bus.pulso_edge !== 1'b0) $display("FAIL edge_held i=%0d got=%b exp=0", i, bus.pulso_edge);
      else n_pass++;
      tick();
      ef = sb_q.pop_front();
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL held_fase i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
      n_checks++;
      if (lamps !== 6'(lamp_q.pop_front())) $display("FAIL held_lamps i=%0d got=%b", i, lamps);
      else n_pass++;
    end
    bus.pulso = 1'b0;
  endtask

  task automatic test_pulso_ignored;
    int pul[13]     = '{1,0,0,1,0,0,0,0,0,0,0,0,0};
    int exp_tab[13] = '{2,2,3,3,4,4,4,4,4,4,4,4,5};
    int ef;
    bit ok;
    wait_fase(2, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL wait_amarelo got=timeout exp=fase 2");
    else n_pass++;
    for (int i = 0; i < 13; i++) begin
      bus.pulso = pul[i][0];
      push_exp(exp_tab[i]);
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL ignored_fase i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
    end
    bus.pulso = 1'b0;
  endtask

  // Strobe lands on the same edge as the green timeout.
  task automatic test_back_to_back;
    int pul[11]     = '{0,0,0,0,0,0,0,1,0,0,0};
    int exp_tab[11] = '{1,1,1,1,1,1,1,2,2,2,3};
    int ef;
    bit ok;
    wait_fase(1, 30, ok);
    n_checks++;
    if (!ok) $display("FAIL wait_verde got=timeout exp=fase 1");
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      bus.pulso = pul[i][0];
      push_exp(exp_tab[i]);
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL b2b_fase i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
    end
    bus.pulso = 1'b0;
  endtask

  task automatic test_manual;
    int cur = 1;
    int ef;
    bit ok;
    wait_fase(1, 30, ok);
    n_checks++;
    if (!ok) $display("FAIL wait_manual got=timeout exp=fase 1");
    else n_pass++;
    bus.modo_manual = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.pulso = 1'b0;
      push_exp(cur);
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL man_low i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
      bus.pulso = 1'b1;
      cur = seguinte(cur);
      push_exp(cur);
      tick();
      ef = sb_q.pop_front();
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL man_step i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
      n_checks++;
      if (lamps !== 6'(lamp_q.pop_front())) $display("FAIL man_lamps i=%0d got=%b", i, lamps);
      else n_pass++;
    end
    bus.pulso = 1'b0;
    tick();
    bus.pulso = 1'b1;
    cur = seguinte(cur);
    for (int i = 0; i < 60; i++) begin
      if (i == 10) bus.pulso = 1'b0;
      push_exp(cur);
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL man_hold i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
    end
  endtask

  // Starts in VERMELHO_1, manual mode.
  task automatic test_mode_switch;
    int exp_tab[24] = '{3,4,4,4,4,4,4,4,4,5,5, 5,5,5,5,5,5,5,5,5,5, 5,5,6};
    int man[24]     = '{0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1,1, 0,0,0};
    int ef;
    for (int i = 0; i < 24; i++) begin
      bus.modo_manual = man[i][0];
      push_exp(exp_tab[i]);
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL mode_fase i=%0d got=%0d exp=%0d", i, bus.fase, ef);
      else n_pass++;
    end
    bus.modo_manual = 1'b0;
  endtask

  task automatic test_async_reset;
    int ef;
    bit ok;
    wait_fase(4, 30, ok);
    n_checks++;
    if (!ok) $display("FAIL wait_verde_b got=timeout exp=fase 4");
    else n_pass++;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.fase !== 3'd0) $display("FAIL async_fase got=%0d exp=0", bus.fase);
    else n_pass++;
    n_checks++;
    if (lamps !== 6'b100_100) $display("FAIL async_lamps got=%b exp=100100", lamps);
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) push_exp(1);
    push_exp(2);
    while (sb_q.size() > 0) begin
      tick();
      ef = sb_q.pop_front();
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL resume_fase t=%0t got=%0d exp=%0d", $time, bus.fase, ef);
      else n_pass++;
      n_checks++;
      if (lamps !== 6'(lamp_q.pop_front())) $display("FAIL resume_lamps t=%0t got=%b", $time, lamps);
      else n_pass++;
    end
  endtask

`ifdef SEMAFORO_PISCA_EN
  task automatic test_pisca;
    int ef;
    bit ok;
    wait_fase(1, 30, ok);
    n_checks++;
    if (!ok) $display("FAIL wait_pisca got=timeout exp=fase 1");
    else n_pass++;
    bus.pisca = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back(7);
      lamp_q.push_back(((i / 4) % 2 == 0) ? 6'b010_010 : 6'b000_000);
    end
    while (sb_q.size() > 0) begin
      tick();
      ef = sb_q.pop_front();
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL pisca_fase got=%0d exp=%0d", bus.fase, ef);
      else n_pass++;
      n_checks++;
      if (lamps !== 6'(lamp_q.pop_front())) $display("FAIL pisca_lamps t=%0t got=%b", $time, lamps);
      else n_pass++;
    end
    bus.pisca = 1'b0;
    push_exp(0);
    push_exp(1);
    while (sb_q.size() > 0) begin
      tick();
      ef = sb_q.pop_front();
      void'(lamp_q.pop_front());
      n_checks++;
      if (bus.fase !== 3'(ef)) $display("FAIL pisca_exit got=%0d exp=%0d", bus.fase, ef);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_timed_sequence();
    test_pulso_green();
    test_pulso_ignored();
    test_back_to_back();
    test_manual();
    test_mode_switch();
    test_async_reset();
`ifdef SEMAFORO_PISCA_EN
    test_pisca();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/semaforo_cruzamento.md
Name: semaforo_cruzamento

Overview:
Parametrised two-approach intersection controller, successor to the single-light, pulse-stepped semaforo. Approaches A and B alternate green/yellow/all-red phases. Phase durations are set by parameters. An edge-detected `pulso` input either shortens the current green (timed mode) or single-steps every phase (manual mode). Sits between the operator/sensor inputs and the lamp drivers.

Parameters:
T_VERDE, 8, green duration in clk cycles (≥1)
T_AMARELO, 3, yellow duration in clk cycles (≥1)
T_VERMELHO, 2, all-red clearance duration in clk cycles (≥1)
CNT_W, 8, phase counter width; every T_* must be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
pulso  input  1  advance request, level; only rising edges act
modo_manual  input  1  0 = timed, 1 = manual single-step
vermelho_a  output  1  approach A red lamp
amarelo_a  output  1  approach A yellow lamp
verde_a  output  1  approach A green lamp
vermelho_b  output  1  approach B red lamp
amarelo_b  output  1  approach B yellow lamp
verde_b  output  1  approach B green lamp
fase  output  3  current state code
pulso_edge  output  1  rising-edge strobe of pulso, one cycle wide

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Edge detect: register `pulso_q` (reset 0); `pulso_edge = pulso & ~pulso_q` (combinational). A held-high `pulso` yields exactly one strobe.
- States and `fase` codes:
  - INICIO = 0
  - VERDE_A = 1
  - AMARELO_A = 2
  - VERMELHO_1 = 3
  - VERDE_B = 4
  - AMARELO_B = 5
  - VERMELHO_2 = 6
  - 7 is reserved for the optional PISCA state.
- Lamp decode (Moore, from state only):
  - INICIO, VERMELHO_1, VERMELHO_2: both reds on.
  - VERDE_A: verde_a and vermelho_b on. AMARELO_A: amarelo_a and vermelho_b on.
  - VERDE_B and AMARELO_B: mirror of the A states.
  - Exactly one lamp per approach is on at all times.
- Reset values: state INICIO, cnt 0, pulso_q 0, vermelho_a = vermelho_b = 1, all other lamps 0, fase 0.
- INICIO → VERDE_A on the first clk edge after reset deasserts, regardless of mode.
- Sequence: VERDE_A → AMARELO_A → VERMELHO_1 → VERDE_B → AMARELO_B → VERMELHO_2 → VERDE_A, wrapping.
- Timed mode (modo_manual = 0):
  - cnt increments each cycle in a state. Advance when cnt == T_state-1; cnt clears to 0 on every state change.
  - Each state therefore lasts exactly T_state cycles. A full cycle is 2*(T_VERDE+T_AMARELO+T_VERMELHO) = 26 cycles at defaults.
  - pulso_edge during VERDE_A/VERDE_B advances to the matching AMARELO at that same clk edge.
  - pulso_edge in AMARELO/VERMELHO states is ignored and not queued.
  - pulso_edge in the same cycle as timeout produces a single advance only.
- Manual mode (modo_manual = 1):
  - cnt is held at 0 and timers are ignored.
  - Every pulso_edge advances one state, in any state except INICIO.
- Mode switch:
  - manual→timed: the current state restarts its full duration (cnt = 0).
  - timed→manual: the state is held and cnt clears next cycle.
- Reset asserted mid-phase: immediately (async) returns to INICIO, both reds on.

Optional Feature:
Macro `SEMAFORO_PISCA_EN`.

When defined:
- Adds parameter T_PISCA (default 4) and input port `pisca` (1 bit).
- pisca = 1 forces state PISCA (fase 7) at the next edge from any state. This has priority over pulso and timers.
- In PISCA, all reds and greens are off. amarelo_a and amarelo_b toggle together every T_PISCA cycles, starting on.
- On pisca deassert, the next edge goes to INICIO, then to VERDE_A.

When undefined:
- No `pisca` port and no PISCA state; fase never equals 7.

Test Plan:
1. Reset for 2 cycles, release, timed mode → fase 0 for 1 cycle, then 1 (VERDE_A) for 8 cycles, 2 for 3, 3 for 2, 4 for 8, 5 for 3, 6 for 2, then back to 1. Assert one-lamp-per-approach every cycle.
2. Timed mode, pulso rises at cycle 2 of VERDE_A and stays high 20 cycles → pulso_edge high one cycle; fase goes to 2 that edge. No further early advance while pulso is held.
3. Timed mode, pulso edge during AMARELO_A and during VERMELHO_1 → durations stay exactly 3 and 2 cycles; no skipped state.
4. Manual mode, pulso low/high pairs of 1 cycle each, 7 times from VERDE_A → fase steps 1,2,3,4,5,6,1,2. Holding pulso high 10 cycles gives exactly one step; no timeout after 50 idle cycles.
5. Reset asserted mid-cycle (between edges) during VERDE_B → lamps go to both-red and fase 0 before the next edge; operation resumes per test 1.
6. With `SEMAFORO_PISCA_EN`, pisca = 1 during VERDE_A → fase 7, yellows toggle every 4 cycles, no red/green. pisca = 0 → fase 0 then 1.
